// File: rtl/scalar_mult.sv
// Elliptic-curve scalar multiplier R = k*G over GF(P), left-to-right double-and-add.
// Holds the affine point_add / point_double units it sequences, plus their shared core.
// Optional build macro SCALAR_MULT_CONST_TIME_EN: run dummy add/double operations so that
// every finite-path bit costs one double plus one add. Results are identical either way.

// Affine add/double core: lambda = num/den, inverse by Fermat, 8 exponent bits per cycle.
module ec_affine_core #(
  parameter logic [255:0] P      = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F,
  parameter bit           Double = 1'b0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [255:0] Px,
  input  logic [255:0] Py,
  input  logic [255:0] Qx,
  input  logic [255:0] Qy,
  output logic         Done,
  output logic [255:0] Rx,
  output logic [255:0] Ry
);
  localparam logic [255:0] InvExp = P - 256'd2;

  function automatic logic [255:0] mod_mul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] prod;
    prod = {256'd0, a} * {256'd0, b};
    return 256'(prod % {256'd0, P});
  endfunction

  function automatic logic [255:0] mod_add(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return 256'(s);
  endfunction

  function automatic logic [255:0] mod_sub(input logic [255:0] a, input logic [255:0] b);
    return (a >= b) ? (a - b) : (a - b + P);
  endfunction

  logic [5:0]   cnt_q, cnt_d;
  logic [255:0] inv_q, inv_d, rx_q, rx_d, ry_q, ry_d;
  logic         done_q, done_d;
  logic [255:0] sq, num, den, lam, x3;
  logic [4:0]   win_idx;
  logic [7:0]   e_win;

  // Slope numerator/denominator from the (stable) operands
  always_comb begin
    sq = mod_mul(Px, Px);
    if (Double) begin
      num = mod_add(mod_add(sq, sq), sq);
      den = mod_add(Py, Py);
    end else begin
      num = mod_sub(Qy, Py);
      den = mod_sub(Qx, Px);
    end
  end

  // 32 windowed square-and-multiply steps, then one cycle to form the result point
  always_comb begin
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    done_d  = done_q;
    win_idx = ~cnt_q[4:0];
    e_win   = InvExp[{win_idx, 3'b000} +: 8];
    lam     = mod_mul(num, inv_q);
    x3      = mod_sub(mod_sub(mod_mul(lam, lam), Px), Qx);
    if (!cnt_q[5]) begin
      for (int i = 7; i >= 0; i--) begin
        inv_d = mod_mul(inv_d, inv_d);
        if (e_win[i]) inv_d = mod_mul(inv_d, den);
      end
      cnt_d = cnt_q + 6'd1;
    end else if (!done_q) begin
      rx_d   = x3;
      ry_d   = mod_sub(mod_mul(lam, mod_sub(Px, x3)), Py);
      done_d = 1'b1;
    end
  end

  // Core state; held cleared while Reset is high
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q  <= '0;
      inv_q  <= 256'd1;
      rx_q   <= '0;
      ry_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      inv_q  <= inv_d;
      rx_q   <= rx_d;
      ry_q   <= ry_d;
      done_q <= done_d;
    end
  end

  assign Done = done_q;
  assign Rx   = rx_q;
  assign Ry   = ry_q;
endmodule

// Affine P+Q; caller guarantees P != +-Q and neither is infinity
module point_add #(
  parameter logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [255:0] Px,
  input  logic [255:0] Py,
  input  logic [255:0] Qx,
  input  logic [255:0] Qy,
  output logic         Done,
  output logic [255:0] Rx,
  output logic [255:0] Ry
);
  ec_affine_core #(.P(P), .Double(1'b0)) u_core (
    .Clk(Clk), .Reset(Reset), .Px(Px), .Py(Py), .Qx(Qx), .Qy(Qy),
    .Done(Done), .Rx(Rx), .Ry(Ry)
  );
endmodule

// Affine 2P; caller guarantees Py != 0
module point_double #(
  parameter logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [255:0] Px,
  input  logic [255:0] Py,
  output logic         Done,
  output logic [255:0] Rx,
  output logic [255:0] Ry
);
  ec_affine_core #(.P(P), .Double(1'b1)) u_core (
    .Clk(Clk), .Reset(Reset), .Px(Px), .Py(Py), .Qx(Px), .Qy(Py),
    .Done(Done), .Rx(Rx), .Ry(Ry)
  );
endmodule

module scalar_mult #(
  parameter logic [255:0] P     = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F,
  parameter int unsigned  NBITS = 256
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [NBITS-1:0] K,
  input  logic [255:0]     Gx,
  input  logic [255:0]     Gy,
  output logic             Busy,
  output logic             Done,
  output logic [255:0]     Rx,
  output logic [255:0]     Ry,
  output logic             Inf
);
  localparam int unsigned IdxW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [2:0] {
    StIdle, StDbl, StDblWait, StAddChk, StAddWait, StAddDblWait, StShift, StFinish
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] k_q, k_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [255:0]     gx_q, gx_d, gy_q, gy_d, ax_q, ax_d, ay_q, ay_d;
  logic [255:0]     dpx_q, dpx_d, dpy_q, dpy_d, rx_q, rx_d, ry_q, ry_d;
  logic             ainf_q, ainf_d, busy_q, busy_d, done_q, done_d, inf_q, inf_d;
  logic             add_rst_q, add_rst_d, dbl_rst_q, dbl_rst_d, discard_q, discard_d;
  logic             add_done, dbl_done;
  logic [255:0]     add_rx, add_ry, dbl_rx, dbl_ry;

  point_add #(.P(P)) u_add (
    .Clk(Clk), .Reset(add_rst_q), .Px(ax_q), .Py(ay_q), .Qx(gx_q), .Qy(gy_q),
    .Done(add_done), .Rx(add_rx), .Ry(add_ry)
  );

  point_double #(.P(P)) u_dbl (
    .Clk(Clk), .Reset(dbl_rst_q), .Px(dpx_q), .Py(dpy_q),
    .Done(dbl_done), .Rx(dbl_rx), .Ry(dbl_ry)
  );

  // Double-and-add sequencing; discard_q marks a dummy operation whose result is dropped
  always_comb begin
    state_d = state_q;  k_d = k_q;      idx_d = idx_q;    gx_d = gx_q;   gy_d = gy_q;
    ax_d    = ax_q;     ay_d = ay_q;    ainf_d = ainf_q;  dpx_d = dpx_q; dpy_d = dpy_q;
    rx_d    = rx_q;     ry_d = ry_q;    inf_d = inf_q;    busy_d = busy_q;
    done_d  = done_q;   discard_d = discard_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          k_d = K;  gx_d = Gx;  gy_d = Gy;  ainf_d = 1'b1;
          idx_d = IdxW'(NBITS - 1);  done_d = 1'b0;  busy_d = 1'b1;  state_d = StDbl;
        end
      end
      StDbl: begin
        if (ainf_q) begin
`ifdef SCALAR_MULT_CONST_TIME_EN
          dpx_d = gx_q;  dpy_d = gy_q;  discard_d = 1'b1;  state_d = StDblWait;
`else
          state_d = StAddChk;
`endif
        end else if (ay_q == '0) begin
          ainf_d  = 1'b1;
          state_d = StAddChk;
        end else begin
          dpx_d = ax_q;  dpy_d = ay_q;  discard_d = 1'b0;  state_d = StDblWait;
        end
      end
      StDblWait: begin
        if (dbl_done) begin
          if (!discard_q) begin
            ax_d = dbl_rx;
            ay_d = dbl_ry;
          end
          state_d = StAddChk;
        end
      end
      StAddChk: begin
        if (!k_q[idx_q]) begin
`ifdef SCALAR_MULT_CONST_TIME_EN
          if (!ainf_q) begin
            discard_d = 1'b1;
            state_d   = StAddWait;
          end else begin
            state_d = StShift;
          end
`else
          state_d = StShift;
`endif
        end else if (ainf_q) begin
          ax_d = gx_q;  ay_d = gy_q;  ainf_d = 1'b0;  state_d = StShift;
        end else if (ax_q == gx_q && ay_q == gy_q) begin
          // A == G: point_add cannot handle it, use the doubler on G instead
          dpx_d = gx_q;  dpy_d = gy_q;  state_d = StAddDblWait;
        end else if (ax_q == gx_q) begin
          ainf_d  = 1'b1;
          state_d = StShift;
        end else begin
          discard_d = 1'b0;
          state_d   = StAddWait;
        end
      end
      StAddWait: begin
        if (add_done) begin
          if (!discard_q) begin
            ax_d = add_rx;
            ay_d = add_ry;
          end
          state_d = StShift;
        end
      end
      StAddDblWait: begin
        if (dbl_done) begin
          ax_d = dbl_rx;  ay_d = dbl_ry;  state_d = StShift;
        end
      end
      StShift: begin
        if (idx_q == '0) begin
          state_d = StFinish;
        end else begin
          idx_d   = idx_q - IdxW'(1);
          state_d = StDbl;
        end
      end
      StFinish: begin
        rx_d  = ainf_q ? '0 : ax_q;
        ry_d  = ainf_q ? '0 : ay_q;
        inf_d = ainf_q;  busy_d = 1'b0;  done_d = 1'b1;  state_d = StIdle;
      end
    endcase
    // Sub-unit resets are released only while their owning wait state is active
    add_rst_d = (state_d != StAddWait);
    dbl_rst_d = !(state_d == StDblWait || state_d == StAddDblWait);
  end

  // State registers; synchronous reset wins in every state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;  k_q <= '0;    idx_q <= '0;     gx_q <= '0;    gy_q <= '0;
      ax_q    <= '0;      ay_q <= '0;   ainf_q <= 1'b1;  dpx_q <= '0;   dpy_q <= '0;
      rx_q    <= '0;      ry_q <= '0;   inf_q <= 1'b1;   busy_q <= 1'b0;
      done_q  <= 1'b0;    discard_q <= 1'b0;  add_rst_q <= 1'b1;  dbl_rst_q <= 1'b1;
    end else begin
      state_q <= state_d;  k_q <= k_d;    idx_q <= idx_d;    gx_q <= gx_d;    gy_q <= gy_d;
      ax_q    <= ax_d;     ay_q <= ay_d;  ainf_q <= ainf_d;  dpx_q <= dpx_d;  dpy_q <= dpy_d;
      rx_q    <= rx_d;     ry_q <= ry_d;  inf_q <= inf_d;    busy_q <= busy_d;
      done_q  <= done_d;   discard_q <= discard_d;  add_rst_q <= add_rst_d;
      dbl_rst_q <= dbl_rst_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Rx   = rx_q;
  assign Ry   = ry_q;
  assign Inf  = inf_q;
endmodule

// File: tb/tb_scalar_mult.sv
// Scoreboard bench for scalar_mult on secp256k1 known-answer vectors.
module tb_scalar_mult;
  localparam logic [255:0] P  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam int unsigned  NBITS = 256;
  localparam logic [255:0] GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;
  localparam logic [255:0] X2 = 256'hC6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5;
  localparam logic [255:0] Y2 = 256'h1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A;
  localparam logic [255:0] X3 = 256'hF9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9;
  localparam logic [255:0] Y3 = 256'h388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672;
  localparam logic [255:0] N  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
  localparam int           Budget = 40000;

  logic             Clk = 1'b0;
  logic             Reset, Start;
  logic [NBITS-1:0] K;
  logic [255:0]     Gx, Gy, Rx, Ry;
  logic             Busy, Done, Inf;

  typedef struct {
    logic [255:0] rx;
    logic [255:0] ry;
    logic         inf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  scalar_mult #(.P(P), .NBITS(NBITS)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .K(K), .Gx(Gx), .Gy(Gy),
    .Busy(Busy), .Done(Done), .Rx(Rx), .Ry(Ry), .Inf(Inf)
  );

  always #5 Clk = ~Clk;

  function automatic exp_t mk(input logic [255:0] x, input logic [255:0] y, input logic i);
    exp_t e;
    e.rx = x;
    e.ry = y;
    e.inf = i;
    return e;
  endfunction

  // One-cycle Start pulse; returns one negedge after the accepting edge
  task automatic drive_start(input logic [255:0] k, input logic [255:0] x, input logic [255:0] y);
    @(negedge Clk);
    K = k;  Gx = x;  Gy = y;  Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < Budget; i++) begin
      if (Done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;  Start = 1'b0;  K = '0;  Gx = '0;  Gy = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", Done); end
    checks++; if (Inf !== 1'b1) begin failures++; $display("FAIL reset_inf: got %0b want 1", Inf); end
    checks++; if (Rx !== '0) begin failures++; $display("FAIL reset_rx: got %h want 0", Rx); end
    checks++; if (Ry !== '0) begin failures++; $display("FAIL reset_ry: got %h want 0", Ry); end
  endtask

  task automatic test_known_vectors();
    logic [255:0] ks[5];
    exp_t         ex[5];
    exp_t         e;
    bit           to;
    ks[0] = 256'd1;  ex[0] = mk(GX, GY, 1'b0);
    ks[1] = 256'd2;  ex[1] = mk(X2, Y2, 1'b0);
    ks[2] = 256'd3;  ex[2] = mk(X3, Y3, 1'b0);
    ks[3] = N;       ex[3] = mk('0, '0, 1'b1);
    ks[4] = N - 1;   ex[4] = mk(GX, P - GY, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive_start(ks[i], GX, GY);
      sb.push_back(ex[i]);
      wait_done(to);
      e = sb.pop_front();
      checks++;
      if (to || Inf !== e.inf || Rx !== e.rx || Ry !== e.ry) begin
        failures++;
        $display("FAIL vec%0d: timeout=%0b Inf=%0b Rx=%h Ry=%h, want Inf=%0b Rx=%h Ry=%h",
                 i, to, Inf, Rx, Ry, e.inf, e.rx, e.ry);
      end
      checks++;
      if (Busy !== 1'b0) begin failures++; $display("FAIL vec%0d_busy: got %0b want 0", i, Busy); end
    end
  endtask

  task automatic test_zero_scalar();
    exp_t e;
    bit   to;
    int   busy_cycles = 0;
    int   sub_active  = 0;
    drive_start(256'd0, GX, GY);
    sb.push_back(mk('0, '0, 1'b1));
    to = 1'b1;
    for (int i = 0; i < Budget; i++) begin
      if (Done === 1'b1) begin
        to = 1'b0;
        break;
      end
      if (Busy === 1'b1) busy_cycles++;
      if (dut.add_rst_q !== 1'b1 || dut.dbl_rst_q !== 1'b1) sub_active++;
      @(negedge Clk);
    end
    e = sb.pop_front();
    checks++;
    if (to || Inf !== e.inf || Rx !== e.rx || Ry !== e.ry) begin
      failures++;
      $display("FAIL zero_result: timeout=%0b Inf=%0b Rx=%h Ry=%h, want Inf=1 Rx=0 Ry=0",
               to, Inf, Rx, Ry);
    end
    checks++;
    if (busy_cycles < int'(NBITS)) begin
      failures++;
      $display("FAIL zero_busy_len: got %0d cycles want >= %0d", busy_cycles, NBITS);
    end
    checks++;
    if (sub_active != 0) begin
      failures++;
      $display("FAIL zero_subunit: got %0d active cycles want 0", sub_active);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    bit   to;
    drive_start(256'd3, GX, GY);
    repeat (100) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %0b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL abort_done: got %0b want 0", Done); end
    checks++; if (Inf !== 1'b1) begin failures++; $display("FAIL abort_inf: got %0b want 1", Inf); end
    Reset = 1'b0;
    drive_start(256'd1, GX, GY);
    sb.push_back(mk(GX, GY, 1'b0));
    wait_done(to);
    e = sb.pop_front();
    checks++;
    if (to || Inf !== e.inf || Rx !== e.rx || Ry !== e.ry) begin
      failures++;
      $display("FAIL abort_restart: timeout=%0b Inf=%0b Rx=%h Ry=%h, want Inf=0 Rx=%h Ry=%h",
               to, Inf, Rx, Ry, e.rx, e.ry);
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    bit   to;
    drive_start(256'd1, GX, GY);
    sb.push_back(mk(GX, GY, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      Start = 1'b1;  K = 256'd2;  Gx = X3;  Gy = Y3;
      @(negedge Clk);
      Start = 1'b0;
    end
    wait_done(to);
    e = sb.pop_front();
    checks++;
    if (to || Inf !== e.inf || Rx !== e.rx || Ry !== e.ry) begin
      failures++;
      $display("FAIL busy_ignore: timeout=%0b Inf=%0b Rx=%h Ry=%h, want Inf=0 Rx=%h Ry=%h",
               to, Inf, Rx, Ry, e.rx, e.ry);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (Done !== 1'b1 || Busy !== 1'b0 || Rx !== e.rx) begin
      failures++;
      $display("FAIL done_hold: Done=%0b Busy=%0b Rx=%h, want Done=1 Busy=0 Rx=%h",
               Done, Busy, Rx, e.rx);
    end
    Gx = GX;  Gy = GY;
  endtask

  // Start held high across FINISH: the next operation is taken only once back in IDLE
  task automatic test_back_to_back();
    exp_t e;
    bit   to;
    @(negedge Clk);
    K = 256'd2;  Gx = GX;  Gy = GY;  Start = 1'b1;
    sb.push_back(mk(X2, Y2, 1'b0));
    @(negedge Clk);
    wait_done(to);
    K = 256'd3;
    sb.push_back(mk(X3, Y3, 1'b0));
    e = sb.pop_front();
    checks++;
    if (to || Inf !== e.inf || Rx !== e.rx || Ry !== e.ry) begin
      failures++;
      $display("FAIL b2b_first: timeout=%0b Inf=%0b Rx=%h Ry=%h, want Inf=0 Rx=%h Ry=%h",
               to, Inf, Rx, Ry, e.rx, e.ry);
    end
    @(negedge Clk);
    Start = 1'b0;
    wait_done(to);
    e = sb.pop_front();
    checks++;
    if (to || Inf !== e.inf || Rx !== e.rx || Ry !== e.ry) begin
      failures++;
      $display("FAIL b2b_second: timeout=%0b Inf=%0b Rx=%h Ry=%h, want Inf=0 Rx=%h Ry=%h",
               to, Inf, Rx, Ry, e.rx, e.ry);
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_zero_scalar();
    test_abort();
    test_busy_ignore();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/scalar_mult.md
Name: scalar_mult

Overview:
- Elliptic-curve scalar multiplication controller: computes R = k·G over GF(P) by left-to-right double-and-add.
- Sits directly downstream of point_add and the doubling unit. It instantiates one point_add and one point_double, sequences them, and consumes their Rx/Ry results into an accumulator.
- Tracks the point at infinity and the P==Q / P==−Q cases explicitly, because point_add cannot handle them.
- Top-level key-generation/ECDH datapath entry point.

Parameters:
- P, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F: field prime, passed to both sub-units.
- NBITS, 256: scalar width; also the number of loop iterations.

Ports:
- Clk  input  1  clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only in IDLE
- K  input  NBITS  scalar; latched on Start
- Gx  input  256  base point x; latched on Start
- Gy  input  256  base point y; latched on Start
- Busy  output  1  high from the cycle after Start acceptance until FINISH
- Done  output  1  result valid; held high in IDLE until the next Start is accepted
- Rx  output  256  result x; 0 when Inf
- Ry  output  256  result y; 0 when Inf
- Inf  output  1  result is the point at infinity

Behaviour:
- Clock and reset: clock Clk; reset Reset, synchronous, active-high.
- Reset values: state=IDLE; Busy=0; Done=0; Inf=1; Rx=Ry=0; idx=0; both sub-unit resets asserted.
- Reset has priority in every state. Reset mid-operation aborts within 1 cycle; no partial result is exposed.
- Sub-unit handshake (point_add and point_double(Clk,Reset,Px,Py,Done,Rx,Ry)):
  - The unit's Reset is held high except while its owning WAIT state is active.
  - Operands are registered and stable for the whole WAIT.
  - On the first cycle the unit's Done=1, the controller latches the unit's Rx/Ry into the accumulator and reasserts the unit's Reset the next cycle.
- Accumulator: Ax, Ay, Ainf.

States and transitions:
- IDLE: on Start=1, latch K, Gx, Gy; set Ainf=1, idx=NBITS-1, Done=0, Busy=1; go DBL.
- DBL:
  - Ainf=1 → ADDCHK (2·O=O, zero wait).
  - Ay=0 → Ainf=1, go ADDCHK.
  - Otherwise → DBL_WAIT.
- DBL_WAIT: on dbl Done, A ← 2A; go ADDCHK.
- ADDCHK:
  - K[idx]=0 → SHIFT.
  - Ainf=1 → A ← G, Ainf=0; go SHIFT.
  - Ax==Gx and Ay==Gy → ADDDBL_WAIT (double G instead).
  - Ax==Gx and Ay!=Gy → Ainf=1; go SHIFT.
  - Otherwise → ADD_WAIT.
- ADD_WAIT: on add Done, A ← A+G; go SHIFT.
- ADDDBL_WAIT: on dbl Done, A ← 2G; go SHIFT.
- SHIFT: idx==0 → FINISH; else idx ← idx−1, go DBL.
- FINISH: Rx/Ry/Inf ← A (zeros if Ainf); Busy=0; Done=1; go IDLE.

Boundary conditions:
- Start while Busy: ignored. K, Gx and Gy changes during Busy: ignored.
- Start asserted in the same cycle FINISH goes to IDLE: not accepted until IDLE.
- K=0: Inf=1 after NBITS iterations, with no sub-unit activity.
- Latency is data-dependent. The bench waits on Done and checks no fixed count.
- G is assumed on-curve; no validation is performed.

Optional Feature:
- Macro: SCALAR_MULT_CONST_TIME_EN.
- Defined:
  - When K[idx]=0 and A is finite, ADDCHK still runs ADD_WAIT with the same operands and discards the result (A unchanged).
  - In DBL with Ainf=1, DBL_WAIT still runs on (Gx,Gy) and discards the result.
  - Result: every finite-path bit costs one double plus one add.
- Undefined: behaviour exactly as in Behaviour; sub-units are skipped when not needed.
- Results are identical in both builds.

Test Plan:
- Reset, then K=1, G=secp256k1 G (79BE667E…16F81798, 483ADA77…FB10D4B8) → Done=1, Inf=0, Rx=Gx, Ry=Gy.
- K=2 → Rx=C6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5, Ry=1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A. This exercises ADDDBL-free doubling.
- K=3 → Rx=F9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9, Ry=388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672.
- K=0 → Inf=1, Rx=Ry=0, Busy fell after NBITS iterations; sub-unit Resets never deasserted.
- K=n=FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141 → Inf=1 (P==−Q path). Also K=n−1 → Rx=Gx, Ry=P−Gy.
- Start K=3, assert Reset after 100 cycles → next cycle Busy=0, Done=0, Inf=1. A new Start with K=1 then gives G. Start pulses during Busy are ignored.
